// File: rtl/awgn_snr_sweep_ctrl_if.sv
// Bundle between the sweep controller, the symbol source, the AWGN channel,
// the bit-error detector and the result collector.
//   master : the controller (drives src_ready, chan_*, snr_sel, rpt_*)
//   slave  : the surrounding datapath / collector
// ERR_W must match the controller's ERR_W.
interface awgn_snr_sweep_ctrl_if #(
  parameter int unsigned ERR_W = 24
);
  logic             src_valid;
  logic             src_ready;
  logic             chan_reset;
  logic             chan_read;
  logic [3:0]       snr_sel;
  logic             err_valid;
  logic             err_bit;
  logic             rpt_valid;
  logic [3:0]       rpt_snr;
  logic [ERR_W-1:0] rpt_errs;
  logic             rpt_sat;

  modport master (
    input  src_valid, err_valid, err_bit,
    output src_ready, chan_reset, chan_read, snr_sel,
           rpt_valid, rpt_snr, rpt_errs, rpt_sat
  );

  modport slave (
    output src_valid, err_valid, err_bit,
    input  src_ready, chan_reset, chan_read, snr_sel,
           rpt_valid, rpt_snr, rpt_errs, rpt_sat
  );
endinterface

// File: rtl/awgn_snr_sweep_ctrl.sv
// BER sweep sequencer for the AWGN channel model. For each SNR index from
// SNR_MIN to SNR_MAX: holds the channel in reset, streams FRAME_LEN source
// symbols through it, drains FLUSH_CYC cycles, then reports the saturating
// count of detector errors seen while streaming/draining.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : one-cycle pulse, starts a sweep (honoured in IDLE only)
//   abort      : returns to IDLE from any active state, no report/done
//   busy       : sweep in progress
//   done       : one-cycle pulse after the last report
//   bus        : source/channel/detector/report signals (master side)
module awgn_snr_sweep_ctrl #(
  parameter int unsigned FRAME_LEN = 320000,
  parameter int unsigned CNT_W     = 20,
  parameter int unsigned SNR_MIN   = 0,
  parameter int unsigned SNR_MAX   = 9,
  parameter int unsigned RST_CYC   = 2,
  parameter int unsigned FLUSH_CYC = 4,
  parameter int unsigned ERR_W     = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  awgn_snr_sweep_ctrl_if.master bus
);

  localparam int unsigned PH_MAX = (RST_CYC > FLUSH_CYC) ? RST_CYC : FLUSH_CYC;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PH_W-1:0]  RST_LAST   = PH_W'(RST_CYC - 1);
  localparam logic [PH_W-1:0]  FLUSH_LAST = PH_W'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0] SYM_LAST   = CNT_W'(FRAME_LEN - 1);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;
  localparam logic [3:0]       SNR_LO     = 4'(SNR_MIN);
  localparam logic [3:0]       SNR_HI     = 4'(SNR_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRST,
    S_STREAM,
    S_FLUSH,
    S_REPORT,
    S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [CNT_W-1:0] sym_q, sym_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             sat_q, sat_d;
  logic [3:0]       snr_q, snr_d;
  logic [3:0]       rpt_snr_q, rpt_snr_d;
  logic [ERR_W-1:0] rpt_errs_q, rpt_errs_d;
  logic             rpt_sat_q, rpt_sat_d;

  logic accept;
  logic err_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ph_q       <= '0;
      sym_q      <= '0;
      err_q      <= '0;
      sat_q      <= 1'b0;
      snr_q      <= SNR_LO;
      rpt_snr_q  <= '0;
      rpt_errs_q <= '0;
      rpt_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      sym_q      <= sym_d;
      err_q      <= err_d;
      sat_q      <= sat_d;
      snr_q      <= snr_d;
      rpt_snr_q  <= rpt_snr_d;
      rpt_errs_q <= rpt_errs_d;
      rpt_sat_q  <= rpt_sat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    sym_d      = sym_q;
    err_d      = err_q;
    sat_d      = sat_q;
    snr_d      = snr_q;
    rpt_snr_d  = rpt_snr_q;
    rpt_errs_d = rpt_errs_q;
    rpt_sat_d  = rpt_sat_q;

    accept  = (state_q == S_STREAM) && bus.src_valid;
    err_hit = ((state_q == S_STREAM) || (state_q == S_FLUSH)) &&
              bus.err_valid && bus.err_bit;

    // Accumulate first so the last FLUSH cycle's error reaches the report.
    if (err_hit) begin
      if (err_q == ERR_MAX) begin
        sat_d = 1'b1;
      end else begin
        err_d = err_q + ERR_W'(1);
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          snr_d   = SNR_LO;
          ph_d    = '0;
          state_d = S_CRST;
        end
      end
      S_CRST: begin
        sym_d = '0;
        err_d = '0;
        sat_d = 1'b0;
        if (ph_q == RST_LAST) begin
          ph_d    = '0;
          state_d = S_STREAM;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_STREAM: begin
        if (accept) begin
          sym_d = sym_q + CNT_W'(1);
          if (sym_q == SYM_LAST) begin
            ph_d    = '0;
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (ph_q == FLUSH_LAST) begin
          rpt_snr_d  = snr_q;
          rpt_errs_d = err_d;
          rpt_sat_d  = sat_d;
          state_d    = S_REPORT;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_REPORT: begin
        if (snr_q == SNR_HI) begin
          state_d = S_FIN;
        end else begin
          snr_d   = snr_q + 4'd1;
          ph_d    = '0;
          state_d = S_CRST;
        end
      end
      S_FIN: begin
        snr_d   = SNR_LO;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a report load already staged above.
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      ph_d       = '0;
      snr_d      = SNR_LO;
      rpt_snr_d  = rpt_snr_q;
      rpt_errs_d = rpt_errs_q;
      rpt_sat_d  = rpt_sat_q;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_FIN);
  assign bus.chan_reset = (state_q == S_IDLE) || (state_q == S_CRST);
  assign bus.chan_read  = accept;
  assign bus.src_ready  = accept;
  assign bus.snr_sel    = snr_q;
  assign bus.rpt_valid  = (state_q == S_REPORT);
  assign bus.rpt_snr    = rpt_snr_q;
  assign bus.rpt_errs   = rpt_errs_q;
  assign bus.rpt_sat    = rpt_sat_q;

endmodule

// File: tb/tb_awgn_snr_sweep_ctrl.sv
// Randomized bench for awgn_snr_sweep_ctrl. Each sweep's stimulus is drawn up
// front; a timeline model derives the expected per-cycle outputs from the
// point windows (reset, stream until FRAME_LEN accepted, drain, report), then
// the stimulus is replayed and every output is compared each cycle.
module tb_awgn_snr_sweep_ctrl;
  localparam int unsigned FRAME_LEN = 8;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned SNR_MIN   = 0;
  localparam int unsigned SNR_MAX   = 2;
  localparam int unsigned RST_CYC   = 2;
  localparam int unsigned FLUSH_CYC = 4;
  localparam int unsigned ERR_W     = 3;
  localparam int          N         = 400;
  localparam int          ERR_CAP   = (1 << ERR_W) - 1;

  logic clk = 1'b0;
  logic reset, start, abort;
  logic busy, done;

  awgn_snr_sweep_ctrl_if #(.ERR_W(ERR_W)) bus ();

  awgn_snr_sweep_ctrl #(
    .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W), .SNR_MIN(SNR_MIN), .SNR_MAX(SNR_MAX),
    .RST_CYC(RST_CYC), .FLUSH_CYC(FLUSH_CYC), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // stimulus
  bit v[N], ev[N], eb[N], st[N], ab[N], rs[N];
  // expected outputs
  bit x_rd[N], x_rst[N], x_busy[N], x_rv[N], x_done[N];
  int x_snr[N], x_rsnr[N], x_rerr[N], x_rsat[N];
  // report values held across sweeps
  int h_snr = 0, h_err = 0, h_sat = 0;
  int last;

  // mode 0: always valid, no errors; 1: random valid, sparse errors;
  // 2: alternating valid, dense errors (saturation); 3: abort 3 cycles into
  // STREAM at the second point; 4: reset during a random FLUSH cycle.
  task automatic build(input int mode);
    int t, s, c, n, r, hits, cut, pick_pt, flush_pick, dens;
    dens       = (mode == 0) ? 0 : (mode == 2) ? 85 : (mode == 1) ? 10 : 30;
    pick_pt    = int'($urandom_range(SNR_MAX, SNR_MIN));
    flush_pick = int'($urandom_range(FLUSH_CYC - 1, 0));
    cut = -1;
    for (int i = 0; i < N; i++) begin
      v[i]  = (mode == 0) ? 1'b1 : (mode == 2) ? (i % 2 == 0)
            : (i >= 200 || $urandom_range(2, 0) != 0);
      ev[i] = ($urandom_range(99, 0) < 90);
      eb[i] = (int'($urandom_range(99, 0)) < dens);
      st[i] = 1'b0; ab[i] = 1'b0; rs[i] = 1'b0;
      x_rd[i] = 1'b0; x_rst[i] = 1'b1; x_busy[i] = 1'b0; x_rv[i] = 1'b0; x_done[i] = 1'b0;
      x_snr[i] = SNR_MIN; x_rsnr[i] = h_snr; x_rerr[i] = h_err; x_rsat[i] = h_sat;
    end
    t = 1;
    for (int k = SNR_MIN; k <= SNR_MAX; k++) begin
      for (c = t; c < t + RST_CYC; c++) begin
        x_busy[c] = 1'b1; x_snr[c] = k;
      end
      s = t + RST_CYC; n = 0; c = s;
      while (n < FRAME_LEN) begin
        x_busy[c] = 1'b1; x_rst[c] = 1'b0; x_snr[c] = k;
        if (v[c]) begin x_rd[c] = 1'b1; n++; end
        c++;
      end
      for (int f = 0; f < FLUSH_CYC; f++) begin
        x_busy[c] = 1'b1; x_rst[c] = 1'b0; x_snr[c] = k;
        if (mode == 4 && k == pick_pt && f == flush_pick) cut = c;
        c++;
      end
      r = c; hits = 0;
      for (int i = s; i < r; i++) if (ev[i] && eb[i]) hits++;
      x_busy[r] = 1'b1; x_rst[r] = 1'b0; x_snr[r] = k; x_rv[r] = 1'b1;
      for (int i = r; i < N; i++) begin
        x_rsnr[i] = k;
        x_rerr[i] = (hits > ERR_CAP) ? ERR_CAP : hits;
        x_rsat[i] = (hits > ERR_CAP) ? 1 : 0;
      end
      if (mode == 3 && k == SNR_MIN + 1) cut = s + 3;
      t = r + 1;
    end
    x_busy[t] = 1'b1; x_rst[t] = 1'b0; x_snr[t] = SNR_MAX; x_done[t] = 1'b1;
    last = t + 4;
    if (cut >= 0) begin
      if (mode == 3) ab[cut] = 1'b1; else rs[cut] = 1'b1;
      for (int i = cut + 1; i < N; i++) begin
        x_rd[i] = 1'b0; x_rst[i] = 1'b1; x_busy[i] = 1'b0; x_rv[i] = 1'b0; x_done[i] = 1'b0;
        x_snr[i]  = SNR_MIN;
        x_rsnr[i] = (mode == 3) ? x_rsnr[cut] : 0;
        x_rerr[i] = (mode == 3) ? x_rerr[cut] : 0;
        x_rsat[i] = (mode == 3) ? x_rsat[cut] : 0;
      end
      last = cut + 4;
    end
    st[0] = 1'b1;
    for (int i = 1; i <= last; i++) begin
      if (x_busy[i] && $urandom_range(5, 0) == 0) st[i] = 1'b1;
      if (!x_busy[i] && $urandom_range(3, 0) == 0) ab[i] = 1'b1;
    end
    h_snr = x_rsnr[last]; h_err = x_rerr[last]; h_sat = x_rsat[last];
  endtask

  task automatic run(input int mode);
    string p;
    build(mode);
    for (int c = 0; c <= last; c++) begin
      @(posedge clk); #1;
      start = st[c]; abort = ab[c]; reset = rs[c];
      bus.src_valid = v[c]; bus.err_valid = ev[c]; bus.err_bit = eb[c];
      @(negedge clk);
      p = $sformatf("m%0d c%0d", mode, c);
      chk({p, " chan_read"},  32'(bus.chan_read),  32'(x_rd[c]));
      chk({p, " src_ready"},  32'(bus.src_ready),  32'(x_rd[c]));
      chk({p, " chan_reset"}, 32'(bus.chan_reset), 32'(x_rst[c]));
      chk({p, " busy"},       32'(busy),           32'(x_busy[c]));
      chk({p, " done"},       32'(done),           32'(x_done[c]));
      chk({p, " snr_sel"},    32'(bus.snr_sel),    x_snr[c]);
      chk({p, " rpt_valid"},  32'(bus.rpt_valid),  32'(x_rv[c]));
      chk({p, " rpt_snr"},    32'(bus.rpt_snr),    x_rsnr[c]);
      chk({p, " rpt_errs"},   32'(bus.rpt_errs),   x_rerr[c]);
      chk({p, " rpt_sat"},    32'(bus.rpt_sat),    x_rsat[c]);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    bus.src_valid = 1'b0; bus.err_valid = 1'b0; bus.err_bit = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst chan_reset", 32'(bus.chan_reset), 32'd1);
    chk("rst chan_read",  32'(bus.chan_read),  32'd0);
    chk("rst busy",       32'(busy),           32'd0);
    chk("rst snr_sel",    32'(bus.snr_sel),    SNR_MIN);
    chk("rst rpt_valid",  32'(bus.rpt_valid),  32'd0);
    chk("rst rpt_errs",   32'(bus.rpt_errs),   32'd0);
    chk("rst done",       32'(done),           32'd0);
    reset = 1'b0;
    run(0); run(1); run(2); run(1); run(3); run(0); run(4); run(2);
    for (int i = 0; i < 6; i++) run(int'($urandom_range(4, 1)));
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
